// File: rtl/mem_port_arbiter_if.sv
// Bundled signals of the fetch/data memory port arbiter: both requester ports and the memory port.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                i_if_req;
  logic [ADDR_W-1:0]   i_if_addr;
  logic                o_if_gnt;
  logic                o_if_rvalid;
  logic [DATA_W-1:0]   o_if_rdata;

  logic                i_d_req;
  logic                i_d_we;
  logic [ADDR_W-1:0]   i_d_addr;
  logic [DATA_W-1:0]   i_d_wdata;
  logic [DATA_W/8-1:0] i_d_be;
  logic                o_d_gnt;
  logic                o_d_rvalid;
  logic [DATA_W-1:0]   o_d_rdata;

  logic                o_mem_req;
  logic                o_mem_we;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_be;
  logic                i_mem_ack;
  logic [DATA_W-1:0]   i_mem_rdata;

  logic                o_busy;
  logic                o_timeout;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ack, i_mem_rdata,
    output o_busy, o_timeout
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ack, i_mem_rdata,
    input  o_busy, o_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between a fetch and a data requester, one transaction in flight,
// alternating grants under contention and aborting transactions the memory never acknowledges.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnIf, OwnD} owner_e;

  state_e              state_q, state_d;
  owner_e              last_gnt_q, last_gnt_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                timeout_q, timeout_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                can_gnt, if_gnt, d_gnt;

  // Under contention the requester not served last wins.
  assign can_gnt = (state_q == StIdle) && !i_reset;
  assign if_gnt  = can_gnt && bus.i_if_req && (!bus.i_d_req || (last_gnt_q == OwnD));
  assign d_gnt   = can_gnt && bus.i_d_req && (!bus.i_if_req || (last_gnt_q == OwnIf));
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (if_gnt) begin
          state_d     = StBusy;
          last_gnt_d  = OwnIf;
          owner_d     = OwnIf;
          cnt_d       = '0;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end else if (d_gnt) begin
          state_d     = StBusy;
          last_gnt_d  = OwnD;
          owner_d     = OwnD;
          cnt_d       = '0;
          mem_we_d    = bus.i_d_we;
          mem_addr_d  = bus.i_d_addr;
          mem_wdata_d = bus.i_d_wdata;
          mem_be_d    = bus.i_d_be;
        end
      end
      StBusy: begin
        if (bus.i_mem_ack) begin
          state_d = StIdle;
          if (owner_q == OwnIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.i_mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = bus.i_mem_rdata;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          // Abort: complete toward the owner with zero data and flag it until reset.
          state_d   = StIdle;
          timeout_d = 1'b1;
          cnt_d     = cnt_inc;
          if (owner_q == OwnIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = '0;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      last_gnt_q  <= OwnIf;
      owner_q     <= OwnIf;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_d_gnt     = d_gnt;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_mem_req   = (state_q == StBusy);
  assign bus.o_busy      = (state_q == StBusy);
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder with programmable ack delay and per-requester
// scoreboards of expected completion data, popped whenever an rvalid pulse appears.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic i_reset;

  int checks = 0;
  int failures = 0;

  int ack_delay = 1;   // busy cycle index carrying the ack; -1 = never
  bit force_ack = 1'b0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] d_model;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.o_if_gnt | bus.o_d_gnt;
    end
    check(tag, got, 1);
  endtask

  task automatic do_reset();
    bus.i_if_req = 1'b0;
    bus.i_d_req  = 1'b0;
    i_reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    d_model = '0;
  endtask

  // Memory responder: acks on busy cycle number ack_delay, read data derived from the address.
  initial begin : mem_model
    int busy_n;
    busy_n = 0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.o_mem_req) begin
        bus.i_mem_ack = (ack_delay >= 0) && (busy_n == ack_delay);
        busy_n++;
      end else begin
        bus.i_mem_ack = force_ack;
        busy_n = 0;
      end
      bus.i_mem_rdata = mem_word(bus.o_mem_addr);
    end
  end

  always @(negedge clk) begin
    if (bus.o_if_gnt || bus.o_d_gnt) begin
      check("gnt_excl", bus.o_if_gnt & bus.o_d_gnt, 0);
      check("gnt_idle", bus.o_busy, 0);
    end
    if (bus.o_if_rvalid) begin
      if (if_q.size() == 0) check("if_rvalid_unexp", bus.o_if_rvalid, 0);
      else check("if_rdata", bus.o_if_rdata, if_q.pop_front());
    end
    if (bus.o_d_rvalid) begin
      if (d_q.size() == 0) check("d_rvalid_unexp", bus.o_d_rvalid, 0);
      else check("d_rdata", bus.o_d_rdata, d_q.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h0;
    bus.i_d_req = 1'b0;
    bus.i_d_we = 1'b0;
    bus.i_d_addr = '0;
    bus.i_d_wdata = '0;
    bus.i_d_be = 4'hF;
    i_reset = 1'b1;
    d_model = '0;

    // Reset state, with a request held to show grants stay blocked.
    @(negedge clk);
    check("rst_if_gnt", bus.o_if_gnt, 0);
    check("rst_mem_req", bus.o_mem_req, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_timeout", bus.o_timeout, 0);
    check("rst_rvalid", {bus.o_if_rvalid, bus.o_d_rvalid}, 0);
    check("rst_rdata", {bus.o_if_rdata, bus.o_d_rdata}, 0);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    check("rst_mem_be", bus.o_mem_be, 0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    bus.i_if_req = 1'b0;

    // Single fetch, ack two cycles after o_mem_req rises.
    ack_delay = 2;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h100;
    @(negedge clk);
    check("fetch_if_gnt", bus.o_if_gnt, 1);
    check("fetch_d_gnt", bus.o_d_gnt, 0);
    if_q.push_back(32'h0050_0093);
    @(posedge clk);
    #1;
    bus.i_if_req = 1'b0;
    bus.i_if_addr = 32'hDEAD_BEEF;
    @(negedge clk);
    check("fetch_mem_req", bus.o_mem_req, 1);
    check("fetch_mem_addr", bus.o_mem_addr, 32'h100);
    check("fetch_mem_we", bus.o_mem_we, 0);
    check("fetch_mem_be", bus.o_mem_be, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("fetch_rvalid_t3", bus.o_if_rvalid, 0);
    @(negedge clk);
    check("fetch_rvalid_t4", bus.o_if_rvalid, 1);

    // Contention right after reset: D, IF, D, IF.
    do_reset();
    ack_delay = 1;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h400;
    bus.i_d_req = 1'b1;
    bus.i_d_we = 1'b0;
    bus.i_d_addr = 32'h800;
    begin
      bit last_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
        bit exp_d;
        wait_gnt("cont_gnt_seen");
        exp_d = !last_d;
        check("cont_d_gnt", bus.o_d_gnt, exp_d);
        check("cont_if_gnt", bus.o_if_gnt, !exp_d);
        if (exp_d) begin
          d_model = mem_word(bus.i_d_addr);
          d_q.push_back(d_model);
        end else begin
          if_q.push_back(mem_word(bus.i_if_addr));
        end
        last_d = exp_d;
        @(posedge clk);
        #1;
        if (exp_d) bus.i_d_addr = bus.i_d_addr + 32'd4;
        else bus.i_if_addr = bus.i_if_addr + 32'd4;
      end
    end
    bus.i_if_req = 1'b0;
    bus.i_d_req = 1'b0;
    repeat (4) @(negedge clk);
    check("cont_if_drained", if_q.size(), 0);
    check("cont_d_drained", d_q.size(), 0);

    // Data write: read data must keep its previous value.
    @(posedge clk);
    #1;
    bus.i_d_req = 1'b1;
    bus.i_d_we = 1'b1;
    bus.i_d_addr = 32'h2000;
    bus.i_d_wdata = 32'hCAFE_F00D;
    bus.i_d_be = 4'h3;
    wait_gnt("wr_gnt_seen");
    check("wr_d_gnt", bus.o_d_gnt, 1);
    d_q.push_back(d_model);
    @(posedge clk);
    #1;
    bus.i_d_req = 1'b0;
    bus.i_d_we = 1'b0;
    bus.i_d_addr = 32'hFFFF_FFF0;
    bus.i_d_wdata = '0;
    bus.i_d_be = 4'hF;
    @(negedge clk);
    check("wr_mem_we", bus.o_mem_we, 1);
    check("wr_mem_addr", bus.o_mem_addr, 32'h2000);
    check("wr_mem_wdata", bus.o_mem_wdata, 32'hCAFE_F00D);
    check("wr_mem_be", bus.o_mem_be, 4'h3);
    repeat (3) @(negedge clk);
    check("wr_rdata_hold", bus.o_d_rdata, d_model);

    // Timeout: no ack, abort after TIMEOUT busy cycles.
    @(posedge clk);
    #1;
    ack_delay = -1;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h300;
    wait_gnt("to_gnt_seen");
    check("to_if_gnt", bus.o_if_gnt, 1);
    if_q.push_back(32'h0);
    @(posedge clk);
    #1;
    bus.i_if_req = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    check("to_busy_last", bus.o_busy, 1);
    check("to_flag_early", bus.o_timeout, 0);
    @(negedge clk);
    check("to_rvalid", bus.o_if_rvalid, 1);
    check("to_flag", bus.o_timeout, 1);
    check("to_mem_req", bus.o_mem_req, 0);
    @(posedge clk);
    #1;
    ack_delay = 1;
    bus.i_d_req = 1'b1;
    bus.i_d_addr = 32'h500;
    wait_gnt("to_rd_gnt_seen");
    check("to_rd_d_gnt", bus.o_d_gnt, 1);
    d_model = mem_word(32'h500);
    d_q.push_back(d_model);
    @(posedge clk);
    #1;
    bus.i_d_req = 1'b0;
    repeat (4) @(negedge clk);
    check("to_flag_sticky", bus.o_timeout, 1);
    check("to_rd_drained", d_q.size(), 0);

    // Reset while busy aborts silently; a later stray ack in idle is ignored.
    @(posedge clk);
    #1;
    ack_delay = -1;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h600;
    wait_gnt("rb_gnt_seen");
    check("rb_if_gnt", bus.o_if_gnt, 1);
    @(posedge clk);
    #1;
    bus.i_if_req = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    d_model = '0;
    @(negedge clk);
    check("rb_mem_req", bus.o_mem_req, 0);
    check("rb_busy", bus.o_busy, 0);
    check("rb_timeout", bus.o_timeout, 0);
    check("rb_if_rvalid", bus.o_if_rvalid, 0);
    check("rb_d_rdata", bus.o_d_rdata, d_model);
    @(posedge clk);
    #1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("stray_busy", bus.o_busy, 0);
    check("stray_rvalid", {bus.o_if_rvalid, bus.o_d_rvalid}, 0);

    // Ack on the very last allowed busy cycle completes normally.
    @(posedge clk);
    #1;
    ack_delay = TIMEOUT - 1;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 32'h700;
    wait_gnt("edge_gnt_seen");
    check("edge_if_gnt", bus.o_if_gnt, 1);
    if_q.push_back(mem_word(32'h700));
    @(posedge clk);
    #1;
    bus.i_if_req = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    check("edge_busy_last", bus.o_busy, 1);
    @(negedge clk);
    check("edge_rvalid", bus.o_if_rvalid, 1);
    check("edge_timeout", bus.o_timeout, 0);
    check("edge_busy", bus.o_busy, 0);

    repeat (3) @(negedge clk);
    check("final_if_q", if_q.size(), 0);
    check("final_d_q", d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
